gray_code_counter: RTL
======================

# gray_code_counter

Parametrised N-bit up/down counter that holds its state in binary and presents a registered Gray-coded copy alongside it. It supersedes the purely combinational binary-to-Gray converter wherever the Gray value comes from a counter, such as FIFO pointers, position counters and clock-domain-crossing indices. It adds direction control, synchronous load, wrap or saturate mode, and a terminal-count flag. Both outputs come from flops, so `gray_out` is glitch-free and safe to sample from another clock domain.

## Interface
- `N`, 16: counter width in bits; legal range 2..32.
- `WRAP`, 1: 1 means wrap-around at the bounds; 0 means saturate at the bounds.

- `clk` input 1: single clock, rising-edge active.
- `rst_n` input 1: synchronous, active-low reset, sampled on the `clk` rising edge.
- `en` input 1: count enable; one step per cycle while high.
- `up` input 1: direction; 1 counts up, 0 counts down. Sampled only when `en`=1.
- `load` input 1: synchronous load strobe.
- `load_val` input N: binary value to load.
- `bin_out` output N: registered binary count.
- `gray_out` output N: registered Gray code of `bin_out`.
- `tc` output 1: registered one-cycle terminal-count pulse.

## Operation
- State: binary register `cnt`[N-1:0], Gray register `g`[N-1:0] and the `tc` flop.
- Gray rule: `g` <= next_cnt ^ (next_cnt >> 1). The MSB equals the binary MSB; every lower bit is XOR of adjacent binary bits. `g` is computed from the next binary value, never from current `g`.
- Priority per edge, highest first:
  - `rst_n`=0: `cnt`=0, `g`=0, `tc`=0.
  - `load`=1: `cnt`=`load_val`, `g`=gray(`load_val`), `tc`=0. `en` and `up` are ignored.
  - `en`=1, `up`=1:
    - `cnt` < 2^N-1: increment.
    - `cnt`=2^N-1 with WRAP=1: `cnt`=0 and `tc`=1.
    - `cnt`=2^N-1 with WRAP=0: hold and `tc`=1.
  - `en`=1, `up`=0:
    - `cnt` > 0: decrement.
    - `cnt`=0 with WRAP=1: `cnt`=2^N-1 and `tc`=1.
    - `cnt`=0 with WRAP=0: hold and `tc`=1.
  - `en`=0: hold `cnt` and `g`; `tc`=0.
- `tc` is 0 on every cycle not listed above. It repeats every cycle while saturated and stepping outward.
- Arithmetic is modulo 2^N with no carry out; no intermediate value is wider than N.
- Invariant: after any step of ±1, `gray_out` differs from its previous value in exactly one bit. A load or a saturate hold gives no such guarantee; a hold keeps 0 bits changed.

## Timing
- Latency is 1 cycle: inputs sampled at edge k appear on `bin_out`, `gray_out` and `tc` after edge k.
- All outputs come straight from flops; there is no combinational input-to-output path.
- Reset values: `bin_out`=0, `gray_out`=0, `tc`=0. These take effect on the first edge with `rst_n`=0 and stay while `rst_n`=0.
- Reset mid-count: the next edge forces 0 regardless of `load` or `en`. The first step after release counts from 0.
- `load` and `en` in the same cycle: the load wins and no step is taken in that cycle.
- Direction change between cycles takes effect immediately, with no dead cycle.
- Throughput: one step per cycle, with no back-pressure.

## Test plan
- Reset, then count up with N=4, WRAP=1 and `en`=1 for 16 cycles.
  - `gray_out` must read 0000, 0001, 0011, 0010, 0110, 0111, 0101, 0100, 1100, 1101, 1111, 1110, 1010, 1011, 1001, 1000, then 0000.
  - `tc`=1 only in the cycle `bin_out` wraps 15→0.
- Down-wrap with N=4, WRAP=1, `up`=0 from 0: `bin_out`=15, `gray_out`=1000, `tc`=1 for one cycle. The next value is 14 / 1001 with `tc`=0.
- Saturate with N=4, WRAP=0.
  - Load 14, then count up for 4 cycles: `bin_out` reads 15, 15, 15, 15 and `tc` reads 0, 1, 1, 1.
  - Counting down from 0 holds 0 with `tc`=1.
- Load priority with N=16: `load`=1, `load_val`=0x1234, `en`=1, `up`=1 → `bin_out`=0x1234, `gray_out`=0x1B2E, `tc`=0. The next cycle without `load` gives 0x1235 / 0x1B2F.
- Reset mid-operation: at `bin_out`=9, drive `rst_n`=0 together with `load`=1 for 1 cycle. Outputs go to 0/0/0; after release with `en`=1 they show 1 / 0001.
- Random run with N=8 over 10k cycles of random `en`, `up` and `load`.
  - Every cycle: `gray_out` == `bin_out` ^ (`bin_out` >> 1).
  - Every non-load, non-hold step: the Hamming distance between consecutive `gray_out` values is exactly 1.

Source files
------------

// File: rtl/gray_code_counter.sv
// N-bit up/down counter with a registered Gray-coded copy of the count.
// Load, wrap/saturate bounds and a one-cycle terminal-count pulse, all from flops.
module gray_code_counter #(
  parameter int N    = 16,
  parameter bit WRAP = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         up,
  input  logic         load,
  input  logic [N-1:0] load_val,
  output logic [N-1:0] bin_out,
  output logic [N-1:0] gray_out,
  output logic         tc
);

  localparam logic [N-1:0] CNT_MAX = {N{1'b1}};
  localparam logic [N-1:0] CNT_ONE = {{(N-1){1'b0}}, 1'b1};

  logic [N-1:0] cnt, g, next_cnt;
  logic         next_tc;

  function automatic logic [N-1:0] bin2gray(input logic [N-1:0] b);
    return b ^ (b >> 1);
  endfunction

  always_comb begin
    next_cnt = cnt;
    next_tc  = 1'b0;
    if (load) begin
      next_cnt = load_val;
    end else if (en) begin
      if (up) begin
        if (cnt == CNT_MAX) begin
          next_tc = 1'b1;
          if (WRAP) next_cnt = '0;
        end else begin
          next_cnt = cnt + CNT_ONE;
        end
      end else begin
        if (cnt == '0) begin
          next_tc = 1'b1;
          if (WRAP) next_cnt = CNT_MAX;
        end else begin
          next_cnt = cnt - CNT_ONE;
        end
      end
    end
  end

  // Gray is always derived from the next binary value so both registers stay coherent.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
      g   <= '0;
      tc  <= 1'b0;
    end else begin
      cnt <= next_cnt;
      g   <= bin2gray(next_cnt);
      tc  <= next_tc;
    end
  end

  assign bin_out  = cnt;
  assign gray_out = g;

endmodule
